// File: rtl/pipelined_alu.sv
// pipelined_alu: two-stage pipelined unsigned ALU with an internal
// multiply-accumulate register and an unsigned overflow flag.
// Each accepted transaction produces one result, in order.
//
// Ports:
//   CLK         clock, rising edge
//   ASYNCRESET  asynchronous active-high reset
//   in_valid    upstream transaction valid
//   in_ready    block can accept this cycle (combinational)
//   a, b        unsigned operands, WIDTH bits
//   op          opcode: 0 ADD, 1 SUB, 2 MUL, 3 ZERO, 4 MAC, 5 AND, 6 OR, 7 ACLR
//   out_valid   result valid
//   out_ready   downstream accepts result
//   c           result, WIDTH bits
//   ovf         unsigned overflow/borrow of the result's operation
module pipelined_alu #(
  parameter int WIDTH = 16,
  parameter int OPW   = 3
) (
  input  logic             CLK,
  input  logic             ASYNCRESET,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [OPW-1:0]   op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic             ovf
);

  localparam logic [OPW-1:0] OP_ADD  = OPW'(0);
  localparam logic [OPW-1:0] OP_SUB  = OPW'(1);
  localparam logic [OPW-1:0] OP_MUL  = OPW'(2);
  localparam logic [OPW-1:0] OP_ZERO = OPW'(3);
  localparam logic [OPW-1:0] OP_MAC  = OPW'(4);
  localparam logic [OPW-1:0] OP_AND  = OPW'(5);
  localparam logic [OPW-1:0] OP_OR   = OPW'(6);
  localparam logic [OPW-1:0] OP_ACLR = OPW'(7);

  logic             vld_p1;
  logic [WIDTH-1:0] a_p1;
  logic [WIDTH-1:0] b_p1;
  logic [OPW-1:0]   op_p1;

  logic             vld_p2;
  logic [WIDTH-1:0] c_p2;
  logic             ovf_p2;
  logic [WIDTH-1:0] acc;

  logic             s1_load;
  logic             s2_load;

  logic [WIDTH:0]     sum;
  logic [WIDTH:0]     diff;
  logic [2*WIDTH-1:0] prod;
  logic               prod_hi;
  logic [WIDTH:0]     mac_sum;
  logic [WIDTH-1:0]   res;
  logic               res_ovf;
  logic [WIDTH-1:0]   acc_nxt;

  // A stage may load when it is empty or when its contents leave this cycle.
  assign s2_load  = !vld_p2 || out_ready;
  assign s1_load  = !vld_p1 || s2_load;
  assign in_ready = s1_load;

  // ---- Stage 1: capture operands on handshake ----
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      vld_p1 <= 1'b0;
    end else if (s1_load) begin
      vld_p1 <= in_valid;
    end
  end

  // Operand registers carry no reset; they are qualified by vld_p1.
  always_ff @(posedge CLK) begin
    if (in_valid && s1_load) begin
      a_p1  <= a;
      b_p1  <= b;
      op_p1 <= op;
    end
  end

  // ---- Stage 2: compute from S1 ----
  always_comb begin
    sum     = {1'b0, a_p1} + {1'b0, b_p1};
    diff    = {1'b0, a_p1} - {1'b0, b_p1};
    prod    = {{WIDTH{1'b0}}, a_p1} * {{WIDTH{1'b0}}, b_p1};
    prod_hi = |prod[2*WIDTH-1:WIDTH];
    mac_sum = {1'b0, acc} + {1'b0, prod[WIDTH-1:0]};
    res     = '0;
    res_ovf = 1'b0;
    acc_nxt = acc;
    case (op_p1)
      OP_ADD:  begin res = sum[WIDTH-1:0];  res_ovf = sum[WIDTH]; end
      OP_SUB:  begin res = diff[WIDTH-1:0]; res_ovf = diff[WIDTH]; end
      OP_MUL:  begin res = prod[WIDTH-1:0]; res_ovf = prod_hi; end
      OP_ZERO: begin res = '0; res_ovf = 1'b0; end
      OP_MAC:  begin
        res     = mac_sum[WIDTH-1:0];
        res_ovf = prod_hi || mac_sum[WIDTH];
        acc_nxt = mac_sum[WIDTH-1:0];
      end
      OP_AND:  begin res = a_p1 & b_p1; res_ovf = 1'b0; end
      OP_OR:   begin res = a_p1 | b_p1; res_ovf = 1'b0; end
      OP_ACLR: begin res = acc; res_ovf = 1'b0; acc_nxt = '0; end
      default: begin res = '0; res_ovf = 1'b0; end
    endcase
  end

  // Result and accumulator only change when a valid S1 entry advances, so a
  // stalled output holds and acc follows transaction order.
  always_ff @(posedge CLK or posedge ASYNCRESET) begin
    if (ASYNCRESET) begin
      vld_p2 <= 1'b0;
      c_p2   <= '0;
      ovf_p2 <= 1'b0;
      acc    <= '0;
    end else if (s2_load) begin
      vld_p2 <= vld_p1;
      if (vld_p1) begin
        c_p2   <= res;
        ovf_p2 <= res_ovf;
        acc    <= acc_nxt;
      end
    end
  end

  assign out_valid = vld_p2;
  assign c         = c_p2;
  assign ovf       = ovf_p2;

endmodule
